// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core's data-memory port and data_mem_responder.
// The core drives the master side; the responder uses the slave side.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: one load/store in flight, 64-bit doubleword array.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses on rsp_err instead of aligning down.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [IdxW+2:0] addr_q;
    logic [63:0]     wdata_q;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            accept, access, mem_we;

    logic [63:0]     mem [DEPTH_WORDS] = '{default: '0};

    logic [IdxW-1:0] idx;
    logic [2:0]      off, size_mask, aoff;
    logic [5:0]      shamt;
    logic [7:0]      lanes, be;
    logic [63:0]     bmask, old_word, new_word, shifted, ld_val;
    logic            misaligned;

    always_comb begin
        size_mask = 3'b000;
        lanes     = 8'h01;
        unique case (size_q)
            2'b00: begin size_mask = 3'b000; lanes = 8'h01; end
            2'b01: begin size_mask = 3'b001; lanes = 8'h03; end
            2'b10: begin size_mask = 3'b011; lanes = 8'h0f; end
            2'b11: begin size_mask = 3'b111; lanes = 8'hff; end
        endcase
    end

    assign idx   = addr_q[IdxW+2:3];
    assign off   = addr_q[2:0];
    assign aoff  = off & ~size_mask;
    assign shamt = {aoff, 3'b000};
    assign be    = lanes << aoff;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |(off & size_mask);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        bmask = '0;
        for (int i = 0; i < 8; i++) begin
            bmask[8*i +: 8] = {8{be[i]}};
        end
    end

    assign old_word = mem[idx];
    assign new_word = (old_word & ~bmask) | ((wdata_q << shamt) & bmask);
    assign shifted  = old_word >> shamt;

    always_comb begin
        ld_val = shifted;
        unique case (size_q)
            2'b00: ld_val = {{56{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01: ld_val = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
            2'b10: ld_val = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
            2'b11: ld_val = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Always pass through StWait so rsp_valid rises exactly LATENCY edges after accept.
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = StResp;
                    rdata_d = (wr_q || misaligned) ? 64'd0 : ld_val;
                    err_d   = misaligned;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset gates the write so a request caught in StWait never commits.
    assign mem_we = access && wr_q && !misaligned && reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= bus.req_write;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr[IdxW+2:0];
            wdata_q <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= new_word;
        end
    end

    assign bus.req_ready = (state_q == StIdle) && reset;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed requests push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_data_mem_responder;
    localparam int unsigned Lat = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit AlignChk = 1'b1;
`else
    localparam bit AlignChk = 1'b0;
`endif

    logic clk;
    logic reset;
    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (Lat)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        e;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   compared   = 0;
    int   mismatched = 0;
    int   next_id    = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: compares each handshaken response against the oldest expectation.
    always @(negedge clk) begin
        if (reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_rsp: got rdata %h with no expectation queued",
                         bus.rsp_rdata);
            end else begin
                cur = sb_q.pop_front();
                check($sformatf("rsp%0d_rdata", cur.id), bus.rsp_rdata, cur.d);
                check($sformatf("rsp%0d_err", cur.id), 64'(bus.rsp_err), 64'(cur.e));
            end
        end
    end

    task automatic issue(input bit w, input bit [1:0] sz, input bit u, input bit [63:0] a,
                         input bit [63:0] wd, input bit [63:0] exp_d, input bit exp_e,
                         input int stall);
        int n;
        exp_t x;
        x.d = exp_d;
        x.e = exp_e;
        x.id = next_id++;
        sb_q.push_back(x);
        bus.rsp_ready    = (stall == 0);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check($sformatf("req%0d_accept_timeout", x.id), 64'(bus.req_ready), 64'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("req%0d_latency", x.id), 64'(n), 64'(Lat));
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                if (i > 0) @(negedge clk);
                check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                check("stall_rsp_rdata", bus.rsp_rdata, exp_d);
                check("stall_req_ready", 64'(bus.req_ready), 64'd0);
            end
            @(posedge clk);
            #1 bus.rsp_ready = 1'b1;
            @(negedge clk);
            check("hs_req_ready", 64'(bus.req_ready), 64'd0);
            @(posedge clk);
            @(negedge clk);
            check("post_hs_req_ready", 64'(bus.req_ready), 64'd1);
            check("post_hs_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

    initial begin
        reset            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b1;

        @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rel_req_ready", 64'(bus.req_ready), 64'd1);
        check("rel_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rel_rsp_rdata", bus.rsp_rdata, 64'd0);
        check("rel_rsp_err", 64'(bus.rsp_err), 64'd0);
        @(posedge clk);
        #1;

        //     w     sz     u     addr                   wdata                  expected
        issue(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 64'h0, 1'b0, 0);
        issue(1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788, 64'h0, 1'b0, 0);
        issue(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 64'h1122334455667788, 1'b0, 0);
        issue(1'b1, 2'b00, 1'b0, 64'h13, 64'hDEADBEEFCAFE12F0, 64'h0, 1'b0, 0);
        issue(1'b0, 2'b00, 1'b0, 64'h13, 64'h0, 64'hFFFFFFFFFFFFFFF0, 1'b0, 0);
        issue(1'b0, 2'b00, 1'b1, 64'h13, 64'h0, 64'h00000000000000F0, 1'b0, 0);
        issue(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 64'h11223344F0667788, 1'b0, 0);
        issue(1'b0, 2'b10, 1'b0, 64'h10, 64'h0, 64'hFFFFFFFFF0667788, 1'b0, 0);
        issue(1'b0, 2'b10, 1'b1, 64'h10, 64'h0, 64'h00000000F0667788, 1'b0, 0);
        issue(1'b0, 2'b01, 1'b0, 64'h16, 64'h0, 64'h0000000000001122, 1'b0, 0);
        // Misaligned half load at 0x13: aligned down to 0x12, or flagged.
        issue(1'b0, 2'b01, 1'b0, 64'h13, 64'h0,
              AlignChk ? 64'h0 : 64'hFFFFFFFFFFFFF066, AlignChk, 0);
        // Upper address bits wrap onto doubleword index 2.
        issue(1'b0, 2'b11, 1'b0, 64'hFFFF000000000810, 64'h0, 64'h11223344F0667788, 1'b0, 0);
        issue(1'b1, 2'b01, 1'b0, 64'h16, 64'h123456789ABCBEEF, 64'h0, 1'b0, 0);
        issue(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 64'hBEEF3344F0667788, 1'b0, 0);
        // Response held off for 5 cycles.
        issue(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 64'hBEEF3344F0667788, 1'b0, 5);

        // Store to 0x20 dropped by a reset while in WAIT.
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b1;
        bus.req_size     = 2'b11;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 64'h20;
        bus.req_wdata    = 64'hAAAAAAAAAAAAAAAA;
        @(negedge clk);
        check("wait_rst_accept_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wait_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 2'b11, 1'b0, 64'h20, 64'h0, 64'h0, 1'b0, 0);

        // Misaligned word store at 0x22: either aligned down to lanes 0x20..0x23 or rejected.
        issue(1'b1, 2'b10, 1'b0, 64'h22, 64'hFFFFFFFFCAFEBABE, 64'h0, AlignChk, 0);
        issue(1'b0, 2'b11, 1'b0, 64'h20, 64'h0,
              AlignChk ? 64'h0 : 64'h00000000CAFEBABE, 1'b0, 0);

        repeat (3) @(posedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
